// File: rtl/stride_prefetcher.sv
// Stride prefetcher: on a confident stride observation, generates PREFETCH_DEPTH
// addresses ahead of value_i (single stride, or alternating two-stride pattern)
// and queues them in a small FIFO for a ready/valid consumer.
// Ports: clk_i/rst_ni clock and async active-low reset; value_i/valid_i observed
// stream; stride_{1,2}_i/_valid_i detected strides; pf_addr_o/pf_valid_o/pf_ready_i
// prefetch queue head; pf_drop_o pulse on a push into a full queue; busy_o while
// generating.
module stride_prefetcher #(
  parameter int unsigned MAX_STRIDE_WIDTH = 5,
  parameter int unsigned PREFETCH_DEPTH   = 2,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [31:0]                 value_i,
  input  logic                        valid_i,
  input  logic [MAX_STRIDE_WIDTH-1:0] stride_1_i,
  input  logic                        stride_1_valid_i,
  input  logic [MAX_STRIDE_WIDTH-1:0] stride_2_i,
  input  logic                        stride_2_valid_i,
  output logic [31:0]                 pf_addr_o,
  output logic                        pf_valid_o,
  input  logic                        pf_ready_i,
  output logic                        pf_drop_o,
  output logic                        busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, GEN} state_e;
  typedef enum logic {SINGLE, DOUBLE} mode_e;

  state_e state_q, state_d;
  mode_e  mode_q;

  logic [2:0]  k_q;
  logic        phase_q;
  logic        start_phase_q;
  logic [31:0] cur_q;
  logic [31:0] s1_q;
  logic [31:0] s2_q;
  logic [31:0] s1_ext;
  logic [31:0] s2_ext;
  logic [31:0] step;
  logic [31:0] next_addr;
  logic        trigger;
  logic        last_step;
  logic        gen_active;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             full;
  logic             pop;
  logic             push;

  assign s1_ext = {{(32-MAX_STRIDE_WIDTH){stride_1_i[MAX_STRIDE_WIDTH-1]}}, stride_1_i};
  assign s2_ext = {{(32-MAX_STRIDE_WIDTH){stride_2_i[MAX_STRIDE_WIDTH-1]}}, stride_2_i};

  // A zero primary stride is only meaningful when paired with a second stride.
  assign trigger   = valid_i & stride_1_valid_i & (stride_2_valid_i | (s1_ext != '0));
  assign last_step = (k_q == 3'(PREFETCH_DEPTH - 1));

  assign step      = ((mode_q == DOUBLE) && (start_phase_q ^ k_q[0])) ? s2_q : s1_q;
  assign next_addr = cur_q + step;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (trigger) state_d = GEN;
      GEN: begin
        if (trigger)        state_d = GEN;
        else if (last_step) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    gen_active = (state_q == GEN);
    busy_o     = gen_active;
  end

  // Sequence datapath; a trigger overrides the in-flight step after its push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q       <= 1'b0;
      start_phase_q <= 1'b0;
      mode_q        <= SINGLE;
      cur_q         <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      k_q           <= '0;
    end else begin
      if (valid_i) phase_q <= ~phase_q;
      if (trigger) begin
        cur_q         <= value_i;
        s1_q          <= s1_ext;
        s2_q          <= s2_ext;
        mode_q        <= stride_2_valid_i ? DOUBLE : SINGLE;
        start_phase_q <= phase_q;
        k_q           <= '0;
      end else if (gen_active) begin
        cur_q <= next_addr;
        k_q   <= last_step ? 3'd0 : k_q + 3'd1;
      end
    end
  end

  // Output queue
  assign full       = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pf_valid_o = (count_q != '0);
  assign pop        = pf_valid_o & pf_ready_i;
  assign push       = gen_active & (~full | pop);
  assign pf_drop_o  = gen_active & ~push;
  assign pf_addr_o  = pf_valid_o ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= next_addr;
  end

endmodule

// File: doc/stride_prefetcher.md
STRIDE_PREFETCHER -- requirements
Module: stride_prefetcher

Interface
REQ-001 SHALL have parameter MAX_STRIDE_WIDTH, default 5, giving the width of the signed stride inputs.
REQ-002 SHALL have parameter PREFETCH_DEPTH, default 2, giving the number of addresses generated per trigger (range 1..7).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving the output queue entries (power of two, at least 2).
REQ-004 SHALL have port clk_i, input, 1, the single clock, with all state on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, which is asynchronous and active-low.
REQ-006 SHALL have port value_i, input, 32, the observed value/address stream.
REQ-007 SHALL have port valid_i, input, 1, marking value_i as valid this cycle.
REQ-008 SHALL have port stride_1_i, input, MAX_STRIDE_WIDTH, the primary detected stride (two's complement).
REQ-009 SHALL have port stride_1_valid_i, input, 1, marking the primary stride as confident.
REQ-010 SHALL have port stride_2_i, input, MAX_STRIDE_WIDTH, the secondary detected stride (two's complement).
REQ-011 SHALL have port stride_2_valid_i, input, 1, marking an alternating two-stride pattern as confident.
REQ-012 SHALL have port pf_addr_o, output, 32, the prefetch address at the FIFO head.
REQ-013 SHALL have port pf_valid_o, output, 1, which is high when the FIFO is non-empty.
REQ-014 SHALL have port pf_ready_i, input, 1, the consumer accept; a pop occurs when pf_valid_o and pf_ready_i are both high.
REQ-015 SHALL have port pf_drop_o, output, 1, a one-cycle pulse when a generated address is discarded because the FIFO is full.
REQ-016 SHALL have port busy_o, output, 1, which is high while the generator is in state GEN.

Function
REQ-017 SHALL keep a phase bit that toggles on every cycle with valid_i high, whatever the stride validity.
REQ-018 SHALL trigger when valid_i is high and stride_1_valid_i is high, capturing value_i as cur, the strides sign-extended to 32 bits, mode (DOUBLE if stride_2_valid_i, else SINGLE), and start_phase (the phase bit before the toggle).
REQ-019 SHALL not trigger in SINGLE mode when the sign-extended stride_1_i is 0, and SHALL not trigger when stride_1_valid_i is low.
REQ-020 SHALL implement two states: IDLE, and GEN with a step counter k counting 0..PREFETCH_DEPTH-1.
REQ-021 SHALL, when in IDLE and a trigger occurs, go to GEN with k=0; otherwise it SHALL stay in IDLE.
REQ-022 SHALL, in GEN each cycle, compute next = cur + step modulo 2^32, attempt a FIFO push of next, set cur to next, and increment k.
REQ-023 SHALL, when in GEN with k = PREFETCH_DEPTH-1, return to IDLE after that push, unless a trigger occurs in the same cycle.
REQ-024 SHALL use step = stride_1 in SINGLE mode.
REQ-025 SHALL, in DOUBLE mode, use step = stride_1 when (start_phase XOR k[0]) is 0, and stride_2 otherwise.
REQ-026 SHALL, when a trigger occurs while in GEN, abort the current sequence: the current-cycle push still happens, then the next cycle restarts at k=0 from the newly captured values.
REQ-027 SHALL make the first address visible on pf_valid_o/pf_addr_o in cycle t+2 when the trigger is in cycle t and the FIFO is empty, with no back-pressure on valid_i.
REQ-028 SHALL accept a push if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
REQ-029 SHALL otherwise drop the address, pulse pf_drop_o for that cycle, leave the count unchanged, and still advance k and cur.
REQ-030 SHALL, on a simultaneous push and pop, leave the count unchanged, with the head advancing and the tail receiving next.
REQ-031 SHALL present the FIFO head combinationally on pf_addr_o; pf_addr_o SHALL hold stable while pf_valid_o is high and pf_ready_i is low.
REQ-032 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with count held in log2(FIFO_DEPTH)+1 bits.

Reset
REQ-033 SHALL, with rst_ni low, asynchronously force state=IDLE, k=0, phase=0, cur=0, strides=0, mode=SINGLE, FIFO pointers and count to 0, pf_valid_o=0, pf_addr_o=0, pf_drop_o=0 and busy_o=0.
REQ-034 SHALL, on reset asserted mid-GEN, discard the sequence and all queued entries, and SHALL not emit a pf_drop_o pulse.
REQ-035 SHALL resume operation on the first rising edge after rst_ni deasserts.

Verification
REQ-036 Single stride: stride_1_i=4 valid, value_i=0x100 in cycle t, pf_ready_i=1 -> pf_addr_o=0x104 in t+2 and 0x108 in t+3, busy_o high in t+1..t+2.
REQ-037 Negative stride with wrap: stride_1_i=5'h1E (-2), value_i=0x00000001 -> addresses 0xFFFFFFFF then 0xFFFFFFFD.
REQ-038 Double stride: stride_1_i=1, stride_2_i=3, start_phase=1, value_i=0x40 -> addresses 0x43 then 0x44.
REQ-039 Back-pressure: pf_ready_i=0 with three triggers of PREFETCH_DEPTH=2 -> 4 entries queued, pf_drop_o pulses twice, the head stays at the first address, and the entries pop in order once pf_ready_i=1.
REQ-040 Abort and gating: a retrigger in the cycle after the first trigger -> one address from the old sequence, then the new sequence; zero stride in SINGLE mode, or stride_1_valid_i=0 -> no pushes and busy_o stays 0.
REQ-041 Reset mid-operation: rst_ni pulsed low with 3 entries queued in GEN -> pf_valid_o=0 immediately, busy_o=0, and no pf_drop_o pulse.
